// File: rtl/des_subkey_sequencer_if.sv
// Handshake/bus bundle between a DES key source, the subkey sequencer and
// the round datapath that consumes the subkeys.
interface des_subkey_sequencer_if;
  logic        start;
  logic        decrypt;
  logic [55:0] key_in;
  logic        subkey_ready;
  logic        subkey_valid;
  logic [47:0] subkey;
  logic [3:0]  round;
  logic        busy;
  logic        done;

  modport master (
    output start, decrypt, key_in, subkey_ready,
    input  subkey_valid, subkey, round, busy, done
  );

  modport slave (
    input  start, decrypt, key_in, subkey_ready,
    output subkey_valid, subkey, round, busy, done
  );
endinterface

// File: rtl/des_subkey_sequencer.sv
// DES key schedule: rotates the PC-1 halves C/D once per accepted subkey and
// presents PC-2(C,D) in encrypt (K1..K16) or decrypt (K16..K1) order.
module des_subkey_sequencer #(
  parameter int unsigned NUM_ROUNDS = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  des_subkey_sequencer_if.slave bus
);

  typedef enum logic {IDLE, GEN} state_t;

  localparam int unsigned PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  state_t      state_q, state_d;
  logic [27:0] c_q, c_d;
  logic [27:0] d_q, d_d;
  logic [3:0]  round_q, round_d;
  logic [3:0]  count_q, count_d;
  logic        dec_q, dec_d;
  logic        done_q, done_d;

  // Rounds 1, 2, 9 and 16 (indices 0, 1, 8, 15) shift by one, all others by two.
  function automatic logic shift_two(input logic [3:0] r);
    return !(r == 4'd0 || r == 4'd1 || r == 4'd8 || r == 4'd15);
  endfunction

  function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  // PC-2 positions are 1-based from the MSB of the 56-bit {C,D} word.
  function automatic logic [47:0] pc2(input logic [27:0] c, input logic [27:0] d);
    logic [55:0] cd;
    logic [47:0] k;
    logic [5:0]  idx;
    cd = {c, d};
    k  = '0;
    for (int unsigned i = 0; i < 48; i++) begin
      idx       = 6'(56 - PC2[i]);
      k[47 - i] = cd[idx];
    end
    return k;
  endfunction

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    round_d = round_q;
    count_d = count_q;
    dec_d   = dec_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = GEN;
          count_d = '0;
          dec_d   = bus.decrypt;
          if (bus.decrypt) begin
            c_d     = bus.key_in[55:28];
            d_d     = bus.key_in[27:0];
            round_d = 4'd15;
          end else begin
            c_d     = rotl(bus.key_in[55:28], 1'b0);
            d_d     = rotl(bus.key_in[27:0], 1'b0);
            round_d = '0;
          end
        end
      end
      GEN: begin
        if (bus.subkey_ready) begin
          if (count_q == 4'(NUM_ROUNDS - 1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            count_d = count_q + 4'd1;
            // Decrypt undoes the shift that produced the current round.
            if (dec_q) begin
              round_d = round_q - 4'd1;
              c_d     = rotr(c_q, shift_two(round_q));
              d_d     = rotr(d_q, shift_two(round_q));
            end else begin
              round_d = round_q + 4'd1;
              c_d     = rotl(c_q, shift_two(round_q + 4'd1));
              d_d     = rotl(d_q, shift_two(round_q + 4'd1));
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      c_q     <= '0;
      d_q     <= '0;
      round_q <= '0;
      count_q <= '0;
      dec_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      round_q <= round_d;
      count_q <= count_d;
      dec_q   <= dec_d;
      done_q  <= done_d;
    end
  end

  assign bus.subkey_valid = (state_q == GEN);
  assign bus.busy         = (state_q == GEN);
  assign bus.done         = done_q;
  assign bus.round        = round_q;
  assign bus.subkey       = pc2(c_q, d_q);

endmodule
